fft_frame_scheduler: RTL and testbench
======================================

# fft_frame_scheduler

Frame-level sequencer for the iterative FFT. It sits in front of the iterative FFT control unit and its working memory. The block accepts one frame of N samples over a valid/ready handshake and generates the working-memory write addresses for it. It then pulses the compute core's START, waits for the core's completion pulse, and streams the N result read addresses out over a second valid/ready handshake before accepting the next frame.

## Interface
Parameters:
- AddrWL, 5: address width; frame length N = 2^AddrWL.
- FrameWL, 8: width of the completed-frame counter.

Ports:
- CLK, in, 1: single clock; all state updates on posedge.
- RST, in, 1: asynchronous, active-high reset.
- EN, in, 1: global enable; low freezes the FSM and all counters.
- IN_VALID, in, 1: upstream sample valid.
- IN_READY, out, 1: scheduler accepts a sample; a transfer occurs when IN_VALID && IN_READY on a posedge.
- LOAD_WE, out, 1: working-memory write enable; equals IN_VALID && IN_READY.
- LOAD_ADDR, out, AddrWL: write address for the current sample.
- CORE_START, out, 1: one-cycle start pulse to the FFT control unit.
- CORE_DONE, in, 1: one-cycle completion pulse from the compute core.
- OUT_VALID, out, 1: result read address valid.
- OUT_READY, in, 1: downstream accepts the address.
- OUT_ADDR, out, AddrWL: natural-order read address.
- OUT_LAST, out, 1: high with OUT_VALID on address N-1.
- BUSY, out, 1: state != IDLE.
- FRAME_CNT, out, FrameWL: count of completed frames; wraps modulo 2^FrameWL.

## Operation
- States are IDLE, LOAD, KICK, RUN and UNLOAD. A single AddrWL-bit counter `cnt` is shared by LOAD and UNLOAD.
- IDLE:
  - With EN=1, go to LOAD next cycle and clear cnt to 0.
  - All handshake outputs are low.
- LOAD:
  - IN_READY = EN.
  - LOAD_ADDR = addr_map(cnt), combinational from cnt.
  - On each transfer, cnt increments.
  - The transfer at cnt == N-1 moves the FSM to KICK and wraps cnt to 0.
- KICK:
  - CORE_START = EN.
  - Go to RUN on the cycle CORE_START is high.
- RUN:
  - Wait for done_seen, a flag set by CORE_DONE.
  - Then go to UNLOAD with cnt = 0 and clear done_seen.
- UNLOAD:
  - OUT_VALID = EN.
  - OUT_ADDR = cnt.
  - OUT_LAST = OUT_VALID && (cnt == N-1).
  - On each transfer, cnt increments.
  - The last transfer increments FRAME_CNT and goes to IDLE.
- done_seen register:
  - Sets on CORE_DONE in any cycle while in RUN or KICK, regardless of EN, so a pulse arriving during EN=0 is not lost.
  - CORE_DONE in IDLE, LOAD or UNLOAD is ignored.
- EN=0:
  - The FSM, cnt and FRAME_CNT hold.
  - IN_READY, LOAD_WE, CORE_START and OUT_VALID are forced low, so no transfer can occur.
  - LOAD_ADDR and OUT_ADDR keep their held values.
- RST asserted at any time, including mid-frame:
  - Immediately forces IDLE, cnt = 0, FRAME_CNT = 0 and done_seen = 0.
  - A partially loaded frame is discarded; there is no resume.
- Reset values: IN_READY 0, LOAD_WE 0, LOAD_ADDR 0, CORE_START 0, OUT_VALID 0, OUT_ADDR 0, OUT_LAST 0, BUSY 0, FRAME_CNT 0.

## Timing
- Transfers are zero-latency: LOAD_WE and LOAD_ADDR are valid in the same cycle as the accepted sample.
- IDLE to first IN_READY: 1 cycle.
- Last sample accepted to CORE_START pulse: 1 cycle.
- CORE_START is high for exactly 1 cycle per frame.
- CORE_DONE to first OUT_VALID: 2 cycles (flag, then state change).
  - A CORE_DONE arriving in the same cycle as CORE_START is captured and gives the same 2-cycle response.
- Throughput: with IN_VALID and OUT_READY held high and EN=1, a frame takes N + 1 + T_core + 2 + N + 1 cycles.
- Read-data alignment for memory latency belongs to the output buffer, not this block.

## Configuration
- Macro: FFT_SCHED_BITREV_EN.
- Defined: addr_map(cnt) = bit-reversed cnt over AddrWL bits, so input is stored in the bit-reversed order required by the in-place iterative FFT.
- Undefined: addr_map(cnt) = cnt (natural order), for cores that bit-reverse at the output.

## Structure
- Shared package fft_sched_pkg holds:
  - state localparams IDLE=0, LOAD=1, KICK=2, RUN=3, UNLOAD=4;
  - state width 3.
- One sub-module: bit_reverse, purely combinational, with parameter WL, mapping in[i] to out[WL-1-i]. It is instantiated only under FFT_SCHED_BITREV_EN.

## Test plan
- Reset, then EN=1 with IN_VALID held high, N=32, FFT_SCHED_BITREV_EN defined:
  - LOAD_ADDR sequence is 0, 16, 8, 24, 4, …, 31;
  - CORE_START pulses once, 1 cycle after the 32nd transfer.
- Same load with the macro undefined:
  - LOAD_ADDR sequence is 0, 1, …, 31.
- CORE_DONE pulsed 5 cycles after CORE_START, OUT_READY held high:
  - OUT_VALID rises 2 cycles later;
  - OUT_ADDR runs 0..31;
  - OUT_LAST is high only at 31;
  - FRAME_CNT goes 0 to 1;
  - BUSY falls after the last transfer.
- Toggle OUT_READY 1,0,1,0 during UNLOAD:
  - OUT_ADDR advances only on cycles with OUT_READY=1;
  - no address is skipped or repeated.
- Drop EN to 0 during RUN and pulse CORE_DONE while EN=0:
  - no progress while EN=0;
  - after EN returns to 1, OUT_VALID appears within 2 cycles, so the done pulse is not lost.
- Assert RST asynchronously after 10 samples are loaded:
  - all outputs go to 0 immediately;
  - the next frame starts at LOAD_ADDR 0 and needs a full 32 samples before CORE_START.

Source files
------------

// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: state encoding shared by the FFT frame scheduler.
package fft_sched_pkg;
    localparam int STATE_WL = 3;
    typedef enum logic [STATE_WL-1:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        KICK   = 3'd2,
        RUN    = 3'd3,
        UNLOAD = 3'd4
    } state_t;
endpackage

// File: rtl/bit_reverse.sv
// bit_reverse: combinational bit-order reversal over WL bits.
module bit_reverse #(
    parameter int WL = 5
) (
    input  logic [WL-1:0] val,
    output logic [WL-1:0] rev
);
    for (genvar i = 0; i < WL; i++) begin : g_bit
        assign rev[WL-1-i] = val[i];
    end
endmodule

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: load/kick/run/unload sequencer for the iterative FFT.
// FFT_SCHED_BITREV_EN stores input samples at bit-reversed addresses.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int AddrWL  = 5,
    parameter int FrameWL = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic               LOAD_WE,
    output logic [AddrWL-1:0]  LOAD_ADDR,
    output logic               CORE_START,
    input  logic               CORE_DONE,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [AddrWL-1:0]  OUT_ADDR,
    output logic               OUT_LAST,
    output logic               BUSY,
    output logic [FrameWL-1:0] FRAME_CNT
);
    localparam logic [AddrWL-1:0] LAST = {AddrWL{1'b1}};
    state_t state;
    logic [AddrWL-1:0] cnt;
    logic [FrameWL-1:0] frame_cnt;
    logic done_seen;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_cnt <= '0;
            done_seen <= 1'b0;
        end else begin
            // done is captured even with EN low so a frozen core pulse is not lost
            if (CORE_DONE && (state == KICK || state == RUN))
                done_seen <= 1'b1;
            if (EN) begin
                case (state)
                    IDLE: begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                    LOAD: if (IN_VALID) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= KICK;
                    end
                    KICK: state <= RUN;
                    RUN: if (done_seen) begin
                        state     <= UNLOAD;
                        cnt       <= '0;
                        done_seen <= 1'b0;
                    end
                    UNLOAD: if (OUT_READY) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state     <= IDLE;
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
    assign IN_READY   = EN && state == LOAD;
    assign LOAD_WE    = IN_VALID && IN_READY;
    assign CORE_START = EN && state == KICK;
    assign OUT_VALID  = EN && state == UNLOAD;
    assign OUT_ADDR   = cnt;
    assign OUT_LAST   = OUT_VALID && cnt == LAST;
    assign BUSY       = state != IDLE;
    assign FRAME_CNT  = frame_cnt;
`ifdef FFT_SCHED_BITREV_EN
    bit_reverse #(.WL(AddrWL)) u_rev (.val(cnt), .rev(LOAD_ADDR));
`else
    assign LOAD_ADDR = cnt;
`endif
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb_fft_frame_scheduler: randomized frame-level check of fft_frame_scheduler.
module tb_fft_frame_scheduler;
    localparam int AW = 5;
    localparam int FW = 8;
    localparam int N  = 1 << AW;
    logic CLK = 1'b0, RST = 1'b1, EN = 1'b0, IN_VALID = 1'b0, CORE_DONE = 1'b0, OUT_READY = 1'b0;
    logic IN_READY, LOAD_WE, CORE_START, OUT_VALID, OUT_LAST, BUSY;
    logic [AW-1:0] LOAD_ADDR, OUT_ADDR;
    logic [FW-1:0] FRAME_CNT;
    int checks = 0, errors = 0, cycles = 0, frames = 0;
    always #5 CLK = ~CLK;
    fft_frame_scheduler #(.AddrWL(AW), .FrameWL(FW)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .LOAD_WE(LOAD_WE), .LOAD_ADDR(LOAD_ADDR), .CORE_START(CORE_START),
        .CORE_DONE(CORE_DONE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_ADDR(OUT_ADDR), .OUT_LAST(OUT_LAST), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cycles);
        end
    endtask
    function automatic logic rnd(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction
    // k-th accepted sample's expected working-memory address
    function automatic logic [31:0] map(input int k);
        logic [31:0] a;
        a = 0;
`ifdef FFT_SCHED_BITREV_EN
        for (int b = 0; b < AW; b++)
            if ((k >> b) & 1) a = a | (32'd1 << (AW - 1 - b));
`else
        a = k;
`endif
        return a;
    endfunction
    task automatic cyc(input logic en, input logic v, input logic r, input logic d);
        @(negedge CLK);
        EN = en; IN_VALID = v; OUT_READY = r; CORE_DONE = d;
        #1;
        cycles++;
        if (cycles > 50000) begin
            $display("FAIL timeout cycles %0d limit 50000", cycles);
            $fatal(1);
        end
    endtask
    // one frame; pr < 0 toggles OUT_READY 1,0,1,0; abort_at >= 0 resets after that many samples
    task automatic run_frame(input int pen, input int pv, input int pr, input int tcore, input int abort_at);
        logic en, v, r;
        int k, t;
        do begin
            en = rnd(pen); v = rnd(pv);
            cyc(en, v, 0, rnd(10));
            chk("idle_busy", BUSY, 0);
            chk("idle_ready", IN_READY, 0);
            chk("idle_we", LOAD_WE, 0);
            chk("idle_frames", FRAME_CNT, frames % 256);
        end while (!en);
        k = 0;
        while (k < N) begin
            en = rnd(pen); v = rnd(pv);
            cyc(en, v, 0, rnd(5));
            chk("load_ready", IN_READY, en);
            chk("load_we", LOAD_WE, en & v);
            chk("load_start", CORE_START, 0);
            chk("load_busy", BUSY, 1);
            if (en && v) begin
                chk("load_addr", LOAD_ADDR, map(k));
                k++;
            end
            if (k == abort_at) begin
                #2 RST = 1'b1; EN = 1'b0;
                #1 chk("rst_outputs", {IN_READY, LOAD_WE, LOAD_ADDR, CORE_START, OUT_VALID,
                                       OUT_ADDR, OUT_LAST, BUSY, FRAME_CNT}, 0);
                @(negedge CLK);
                RST = 1'b0;
                frames = 0;
                return;
            end
        end
        do begin
            en = rnd(pen);
            cyc(en, rnd(pv), 0, en && tcore == 0);
            chk("kick_start", CORE_START, en);
            chk("kick_ready", IN_READY, 0);
        end while (!en);
        for (t = 1; t <= tcore; t++) begin
            en = rnd(pen);
            cyc(en, 0, rnd(50), t == tcore);
            chk("run_start", CORE_START, 0);
            chk("run_valid", OUT_VALID, 0);
        end
        do begin
            en = rnd(pen);
            cyc(en, 0, 1, 0);
            chk("wait_valid", OUT_VALID, 0);
            chk("wait_busy", BUSY, 1);
        end while (!en);
        k = 0; t = 0;
        while (k < N) begin
            en = rnd(pen);
            r = (pr < 0) ? (t % 2 == 0) : rnd(pr);
            t++;
            cyc(en, 0, r, rnd(5));
            chk("out_valid", OUT_VALID, en);
            chk("out_addr", OUT_ADDR, k);
            chk("out_last", OUT_LAST, en && k == N - 1);
            chk("out_frames", FRAME_CNT, frames % 256);
            if (en && r) k++;
        end
        frames++;
    endtask
    initial begin
        repeat (2) @(negedge CLK);
        #1 chk("reset_outputs", {IN_READY, LOAD_WE, LOAD_ADDR, CORE_START, OUT_VALID,
                                 OUT_ADDR, OUT_LAST, BUSY, FRAME_CNT}, 0);
        RST = 1'b0;
        run_frame(100, 100, 100, 5, -1);
        run_frame(100, 100, -1, 3, -1);
        run_frame(100, 100, 100, 0, -1);
        run_frame(100, 100, 100, 5, 10);
        run_frame(100, 100, 100, 5, -1);
        run_frame(40, 100, 100, 6, -1);
        for (int i = 0; i < 20; i++)
            run_frame(60, 70, 60, int'($urandom_range(12)), -1);
        run_frame(100, 100, 100, 1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
